// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron datapath: fixed-point format,
// saturation limits, the accumulator FSM states and the saturating adder.
package snn_pkg;

  localparam int DW_DEF     = 16;
  localparam int INT_DW_DEF = 8;
  localparam int W_DEF      = DW_DEF + INT_DW_DEF;

  localparam logic [W_DEF-1:0] SAT_MAX = {1'b0, {(W_DEF-1){1'b1}}};
  localparam logic [W_DEF-1:0] SAT_MIN = {1'b1, {(W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  // Signed add one bit wider than the operands; if the two top bits of the
  // wide sum disagree the result left the representable range and is clamped.
  function automatic logic [W_DEF-1:0] sat_add(input logic [W_DEF-1:0] a,
                                               input logic [W_DEF-1:0] b);
    logic [W_DEF:0] sum_s;
    sum_s = {a[W_DEF-1], a} + {b[W_DEF-1], b};
    if (sum_s[W_DEF] != sum_s[W_DEF-1]) begin
      if (sum_s[W_DEF]) begin
        sat_add = SAT_MIN;
      end else begin
        sat_add = SAT_MAX;
      end
    end else begin
      sat_add = sum_s[W_DEF-1:0];
    end
  endfunction

endpackage

// File: rtl/synapse_weight_ram.sv
// Synaptic weight store: N x W registers, one clocked write port and one
// combinational read port. A write and a read of the same entry in one cycle
// return the old value; the new value is visible from the next cycle.
module synapse_weight_ram
  import snn_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = W_DEF,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_r [N];

  // Clear all weights on reset; otherwise store in-range writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en && (int'(wr_addr) < N)) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Combinational read; addresses past the array return zero.
  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < N) begin
      rd_data = mem_r[rd_addr];
    end else begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/synapse_accumulator.sv
// Per-time-step synapse accumulator: on start, snapshots the presynaptic spike
// vector and serially sums the weights of the spiking inputs, one synapse per
// clock through a single saturating adder, then presents the sum with a
// one-cycle sum_valid pulse.
module synapse_accumulator
  import snn_pkg::*;
#(
  parameter int N_PRE  = 8,
  parameter int DW     = DW_DEF,
  parameter int INT_DW = INT_DW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_PRE-1:0]      pre_spikes,
  input  logic                  wr_en,
  input  logic [$clog2(N_PRE)-1:0] wr_addr,
  input  logic [DW+INT_DW-1:0]  wr_data,
  output logic                  busy,
  output logic                  sum_valid,
  output logic [DW+INT_DW-1:0]  spiking_value
);

  localparam int W  = DW + INT_DW;
  localparam int AW = $clog2(N_PRE);

  acc_state_t       state_r;
  logic [N_PRE-1:0] snap_r;
  logic [W-1:0]     acc_r;
  logic [AW-1:0]    idx_r;
  logic             busy_r;
  logic             sum_valid_r;
  logic [W-1:0]     spiking_value_r;
  logic [W-1:0]     w_rd_s;
  logic [W-1:0]     acc_next_s;

  synapse_weight_ram #(
    .N  (N_PRE),
    .W  (W),
    .AW (AW)
  ) u_weights (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_r),
    .rd_data (w_rd_s)
  );

  // Next accumulator value: add the current synapse's weight only if it spiked.
  always_comb begin
    acc_next_s = acc_r;
    if (snap_r[idx_r]) begin
      acc_next_s = sat_add(acc_r, w_rd_s);
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Sequencer: IDLE waits for start, ACCUM walks every synapse, DONE publishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      snap_r          <= '0;
      acc_r           <= '0;
      idx_r           <= '0;
      busy_r          <= 1'b0;
      sum_valid_r     <= 1'b0;
      spiking_value_r <= '0;
    end else begin
      sum_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= ACCUM;
            snap_r  <= pre_spikes;
            acc_r   <= '0;
            idx_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        ACCUM: begin
          acc_r <= acc_next_s;
          idx_r <= idx_r + AW'(1);
          if (idx_r == AW'(N_PRE - 1)) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          spiking_value_r <= acc_r;
          sum_valid_r     <= 1'b1;
          busy_r          <= 1'b0;
          state_r         <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_r;
  assign sum_valid     = sum_valid_r;
  assign spiking_value = spiking_value_r;

endmodule

// File: tb/tb_synapse_accumulator.sv
// Directed bench for synapse_accumulator: expected sums are queued when a
// time step is started and checked when sum_valid pulses.
module tb_synapse_accumulator;

  localparam int N_PRE = 8;
  localparam int W     = 24;
  localparam int AW    = 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic [N_PRE-1:0] pre_spikes;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [W-1:0]     wr_data;
  logic             busy;
  logic             sum_valid;
  logic [W-1:0]     spiking_value;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int pulses     = 0;
  int n_popped   = 0;
  int valid_cyc  = 0;
  int start_cyc  = 0;
  int pulses_before = 0;
  logic [W-1:0] exp_q [$];

  synapse_accumulator #(.N_PRE(N_PRE), .DW(16), .INT_DW(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pre_spikes    (pre_spikes),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .sum_valid     (sum_valid),
    .spiking_value (spiking_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure start-to-sum_valid latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every sum_valid pulse must match the oldest queued sum.
  always @(negedge clk) begin
    if (sum_valid === 1'b1) begin
      pulses++;
      valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL unexpected_sum_valid observed=%h expected=no_pulse", spiking_value);
      end else begin
        check("spiking_value", 32'(spiking_value), 32'(exp_q.pop_front()));
        n_popped++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic write_w(input int a, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic write_all(input logic [W-1:0] d);
    for (int i = 0; i < N_PRE; i++) write_w(i, d);
  endtask

  // Drive start across one edge (edge 0); returns 1 time unit after it.
  task automatic start_step(input logic [N_PRE-1:0] spk, input logic [W-1:0] exp, input bit push);
    pre_spikes = spk;
    start      = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    start         = 1'b0;
    start_cyc     = cyc;
    pulses_before = pulses;
    pre_spikes    = ~spk;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 30 && n_popped < target; k++) @(posedge clk);
    #1;
    check("done_seen", 32'(n_popped >= target), 32'd1);
    check("latency", 32'(valid_cyc - start_cyc), 32'd9);
    repeat (2) @(posedge clk);
    #1;
    check("one_pulse", 32'(pulses - pulses_before), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic run_step(input logic [N_PRE-1:0] spk, input logic [W-1:0] exp);
    int target;
    target = n_popped + 1;
    start_step(spk, exp, 1'b1);
    wait_done(target);
  endtask

  initial begin
    int target;
    rst        = 1'b1;
    start      = 1'b0;
    pre_spikes = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum_valid", 32'(sum_valid), 32'd0);
    check("rst_value", 32'(spiking_value), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // All-ones weights, all inputs spiking.
    write_all(24'h010000);
    run_step(8'hFF, 24'h080000);

    // Weight equals index, sparse spike pattern: 0+2+5+7.
    for (int i = 0; i < N_PRE; i++) write_w(i, 24'(i * 32'h010000));
    run_step(8'hA5, 24'h0E0000);

    // Positive and negative saturation.
    write_all(24'h7F0000);
    run_step(8'hFF, 24'h7FFFFF);
    write_all(24'h800000);
    run_step(8'hFF, 24'h800000);

    // All-zero snapshot still pulses with a zero sum.
    run_step(8'h00, 24'h000000);

    // Mixed signs; a second start during ACCUM is ignored.
    write_w(0, 24'h030000);
    write_w(1, 24'hFB0000);
    target = n_popped + 1;
    start_step(8'h03, 24'hFE0000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    start      = 1'b1;
    pre_spikes = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(target);
    check("value_held", 32'(spiking_value), 32'h00FE0000);

    // Write to the weight being read in the same ACCUM cycle: old value used.
    write_all(24'h010000);
    target = n_popped + 1;
    start_step(8'h08, 24'h010000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    wr_en   = 1'b1;
    wr_addr = 3'd3;
    wr_data = 24'h020000;
    @(posedge clk); #1;
    wr_en = 1'b0;
    wait_done(target);
    run_step(8'h08, 24'h020000);

    // Reset in the middle of ACCUM: no pulse, outputs and weights cleared.
    write_all(24'h010000);
    start_step(8'hFF, 24'h000000, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_value", 32'(spiking_value), 32'd0);
    check("midrst_sum_valid", 32'(sum_valid), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_pulse", 32'(pulses - pulses_before), 32'd0);
    run_step(8'hFF, 24'h000000);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
